// File: rtl/cipher_ctrl.sv
// Byte-serial stream-cipher controller: key/IV load, warm-up, bitwise XOR via engine.
// Optional processed-byte counter enabled by macro CIPHER_CTRL_BYTE_CNT_EN.
`timescale 1ns/1ps
module cipher_ctrl #(
  parameter int unsigned WARMUP_CYC = 1152
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  output logic        busy_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_byte_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_byte_o,
  output logic [15:0] byte_cnt_o,
  output logic        eng_ce_o,
  output logic        eng_ld_init_o,
  output logic        eng_dat_o,
  output logic [79:0] eng_key_o,
  output logic [79:0] eng_iv_o,
  input  logic        eng_dat_i
);

  localparam int unsigned CW =
    (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARMUP,
    READY,
    SHIFT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    din;
  logic [7:0]    dres;
  logic [7:0]    res_n;
  logic [7:0]    out_byte_q;
  logic          out_valid_q;
  logic [79:0]   key_q;
  logic [79:0]   iv_q;
  logic          restart;
  logic          accept;
  logic          drain;
  logic          last_bit;

  assign restart = start_i &&
    (state == IDLE || state == READY || state == SHIFT);
  assign accept   = in_valid_i && in_ready_o;
  assign drain    = out_valid_q && out_ready_i;
  assign last_bit = (state == SHIFT) && (idx == 3'd7);

  always_comb begin
    res_n      = dres;
    res_n[idx] = eng_dat_i;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      din         <= '0;
      dres        <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      key_q       <= '0;
      iv_q        <= '0;
    end else if (restart) begin
      key_q       <= key_i;
      iv_q        <= iv_i;
      out_valid_q <= 1'b0;
      state       <= LOAD;
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        LOAD: begin
          cnt   <= CW'(WARMUP_CYC - 1);
          state <= WARMUP;
        end
        WARMUP: begin
          if (cnt == '0) state <= READY;
          else cnt <= cnt - CW'(1);
        end
        READY: begin
          if (drain) out_valid_q <= 1'b0;
          if (accept) begin
            din   <= in_byte_i;
            idx   <= 3'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          dres <= res_n;
          idx  <= idx + 3'd1;
          if (idx == 3'd7) begin
            out_byte_q  <= res_n;
            out_valid_q <= 1'b1;
            state       <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CIPHER_CTRL_BYTE_CNT_EN
  logic [15:0] byte_cnt_q;

  // Discarded in-flight bytes never reach last_bit, so they are not counted.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) byte_cnt_q <= '0;
    else if (restart) byte_cnt_q <= '0;
    else if (last_bit) byte_cnt_q <= byte_cnt_q + 16'd1;
  end

  assign byte_cnt_o = byte_cnt_q;
`else
  assign byte_cnt_o = 16'd0;
`endif

  assign busy_o        = (state == LOAD) || (state == WARMUP);
  assign in_ready_o    = (state == READY) &&
                         (!out_valid_q || out_ready_i);
  assign eng_ce_o      = (state == LOAD) || (state == WARMUP) ||
                         (state == SHIFT);
  assign eng_ld_init_o = (state == LOAD);
  assign eng_dat_o     = (state == SHIFT) && din[idx];
  assign out_valid_o   = out_valid_q;
  assign out_byte_o    = out_byte_q;
  assign eng_key_o     = key_q;
  assign eng_iv_o      = iv_q;

endmodule
